sprite_motion: RTL and testbench

Parametrised per-frame kinematics engine for a keyboard-driven sprite: signed X/Y velocity with acceleration, friction, gravity, grounded-only jumping, configurable wall response (clamp or bounce) and a pause input. Clocked once per video frame, it sits between the keycode decoder and the sprite/colour-mapper logic, supplying position, size, velocity and a grounded flag. Velocity updates are applied to position in the same frame, with no one-frame stale-velocity lag.

---
 rtl/sprite_motion_if.sv | 24 ++
 rtl/sprite_motion.sv | 138 +++++++++++++
 tb/tb_sprite_motion.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_motion_if.sv
// Keycode/pause inputs and kinematic outputs between the keycode decoder,
// the motion engine and the sprite/colour-mapper logic.
interface sprite_motion_if #(
  parameter int unsigned W = 10
);
  logic [7:0]   keycode;
  logic         Pause;
  logic [W-1:0] PosX;
  logic [W-1:0] PosY;
  logic [W-1:0] Size;
  logic [W-1:0] VelX;
  logic [W-1:0] VelY;
  logic         Grounded;

  modport master (
    output keycode, Pause,
    input  PosX, PosY, Size, VelX, VelY, Grounded
  );

  modport slave (
    input  keycode, Pause,
    output PosX, PosY, Size, VelX, VelY, Grounded
  );
endinterface

// File: rtl/sprite_motion.sv
// Per-frame sprite kinematics: keyboard acceleration, friction, gravity, jumping
// and wall response, with the new velocity applied to position on the same edge.
module sprite_motion #(
  parameter int unsigned W            = 10,
  parameter int          X_MIN        = 10,
  parameter int          X_MAX        = 629,
  parameter int          Y_MIN        = 10,
  parameter int          Y_MAX        = 469,
  parameter int          X_START      = 320,
  parameter int          Y_START      = 240,
  parameter int          SIZE         = 4,
  parameter int          V_MAX        = 8,
  parameter int          ACCEL_PERIOD = 4,
  parameter int          GRAV_PERIOD  = 4,
  parameter int          JUMP_V       = 6,
  parameter int          WALL_MODE    = 0,
  parameter logic [7:0]  KEY_LEFT     = 8'h04,
  parameter logic [7:0]  KEY_RIGHT    = 8'h07,
  parameter logic [7:0]  KEY_JUMP     = 8'h1A
) (
  input  logic             frame_clk,
  input  logic             Reset,
  sprite_motion_if.slave   bus
);

  localparam int unsigned AW = $clog2(ACCEL_PERIOD + 1);
  localparam int unsigned GW = $clog2(GRAV_PERIOD + 1);

  localparam logic signed [W:0]   XLo     = (W+1)'(X_MIN + SIZE);
  localparam logic signed [W:0]   XHi     = (W+1)'(X_MAX - SIZE);
  localparam logic signed [W:0]   YLo     = (W+1)'(Y_MIN + SIZE);
  localparam logic signed [W:0]   YHi     = (W+1)'(Y_MAX - SIZE);
  localparam logic signed [W-1:0] VMax    = W'(V_MAX);
  localparam logic signed [W-1:0] VMin    = W'(-V_MAX);
  localparam logic signed [W-1:0] JumpVel = W'(-JUMP_V);
  localparam logic signed [W-1:0] One     = W'(1);
  localparam logic [AW-1:0]       AxLast  = AW'(ACCEL_PERIOD - 1);
  localparam logic [GW-1:0]       GLast   = GW'(GRAV_PERIOD - 1);
  localparam logic                GroundInit = (Y_START == Y_MAX - SIZE);

  logic [W-1:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic                grounded_q, grounded_d;
  logic [AW-1:0]       ax_cnt_q, ax_cnt_d;
  logic [GW-1:0]       g_cnt_q, g_cnt_d;

  logic                accel_tick, grav_tick;
  logic signed [W-1:0] vx_raw, vy_raw, vx_new, vy_new;
  logic signed [W:0]   cand_x, cand_y;

  always_comb begin
    accel_tick = (ax_cnt_q == AxLast);
    grav_tick  = (g_cnt_q == GLast);

    vx_raw = vel_x_q;
    if (accel_tick) begin
      if (bus.keycode == KEY_LEFT)       vx_raw = vel_x_q - One;
      else if (bus.keycode == KEY_RIGHT) vx_raw = vel_x_q + One;
      else if (vel_x_q[W-1])             vx_raw = vel_x_q + One;
      else if (|vel_x_q)                 vx_raw = vel_x_q - One;
    end

    // Jump launch is not gated by the gravity tick.
    vy_raw = vel_y_q;
    if (grounded_q && bus.keycode == KEY_JUMP) vy_raw = JumpVel;
    else if (grounded_q)                       vy_raw = '0;
    else if (grav_tick)                        vy_raw = vel_y_q + One;

    vx_new = vx_raw;
    if (vx_raw > VMax)      vx_new = VMax;
    else if (vx_raw < VMin) vx_new = VMin;
    vy_new = vy_raw;
    if (vy_raw > VMax)      vy_new = VMax;
    else if (vy_raw < VMin) vy_new = VMin;

    cand_x = {1'b0, pos_x_q} + {vx_new[W-1], vx_new};
    cand_y = {1'b0, pos_y_q} + {vy_new[W-1], vy_new};

    pos_x_d = cand_x[W-1:0];
    vel_x_d = vx_new;
    if (cand_x > XHi || cand_x < XLo) begin
      pos_x_d = (cand_x > XHi) ? XHi[W-1:0] : XLo[W-1:0];
      vel_x_d = (WALL_MODE == 1) ? -vx_new : '0;
    end

    pos_y_d = cand_y[W-1:0];
    vel_y_d = vy_new;
    if (cand_y >= YHi) begin
      pos_y_d = YHi[W-1:0];
      vel_y_d = '0;
    end else if (cand_y < YLo) begin
      pos_y_d = YLo[W-1:0];
      vel_y_d = '0;
    end
    grounded_d = (pos_y_d == YHi[W-1:0]);

    ax_cnt_d = accel_tick ? '0 : ax_cnt_q + AW'(1);
    g_cnt_d  = grav_tick  ? '0 : g_cnt_q + GW'(1);

    if (bus.Pause) begin
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      vel_x_d    = vel_x_q;
      vel_y_d    = vel_y_q;
      grounded_d = grounded_q;
      ax_cnt_d   = ax_cnt_q;
      g_cnt_d    = g_cnt_q;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      pos_x_q    <= W'(X_START);
      pos_y_q    <= W'(Y_START);
      vel_x_q    <= '0;
      vel_y_q    <= '0;
      grounded_q <= GroundInit;
      ax_cnt_q   <= '0;
      g_cnt_q    <= '0;
    end else begin
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      vel_x_q    <= vel_x_d;
      vel_y_q    <= vel_y_d;
      grounded_q <= grounded_d;
      ax_cnt_q   <= ax_cnt_d;
      g_cnt_q    <= g_cnt_d;
    end
  end

  assign bus.PosX     = pos_x_q;
  assign bus.PosY     = pos_y_q;
  assign bus.Size     = W'(SIZE);
  assign bus.VelX     = vel_x_q;
  assign bus.VelY     = vel_y_q;
  assign bus.Grounded = grounded_q;

endmodule

// File: tb/tb_sprite_motion.sv
// Bench for sprite_motion: two instances (clamp and bounce/high-jump) checked every
// frame against an integer kinematics model, plus literal scenario expectations.
module tb_sprite_motion;
  localparam int W = 10;
  localparam logic [7:0] KL = 8'h04, KR = 8'h07, KJ = 8'h1A;
  localparam int XLO = 14, XHI = 625, YLO = 14, YHI = 465, VM = 8;

  logic frame_clk = 1'b0;
  logic Reset = 1'b0;
  always #5 frame_clk = ~frame_clk;

  sprite_motion_if #(.W(W)) bus0();
  sprite_motion_if #(.W(W)) bus1();

  sprite_motion #(.W(W)) dut0 (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus0.slave)
  );

  sprite_motion #(.W(W), .WALL_MODE(1), .JUMP_V(8), .GRAV_PERIOD(16)) dut1 (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus1.slave)
  );

  typedef struct {
    int px, py, vx, vy, gr, ax, gc;
  } st_t;

  st_t m[2];
  int  jv[2] = '{6, 8};
  int  gp[2] = '{4, 16};
  int  wm[2] = '{0, 1};
  bit  mvalid = 1'b0;
  int  checks = 0;
  int  errors = 0;

  function automatic int sat(int v);
    return (v > VM) ? VM : ((v < -VM) ? -VM : v);
  endfunction

  function automatic int sv(logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // One frame of motion from the plain rules, integer arithmetic.
  function automatic st_t step(st_t s, int i, logic rn, logic pz, logic [7:0] k);
    st_t n;
    int vx, vy, cx, cy;
    if (!rn) begin
      n.px = 320; n.py = 240; n.vx = 0; n.vy = 0;
      n.gr = (240 == YHI) ? 1 : 0; n.ax = 0; n.gc = 0;
      return n;
    end
    if (pz) return s;
    n  = s;
    vx = s.vx;
    if (s.ax == 3) begin
      if (k == KL)      vx = vx - 1;
      else if (k == KR) vx = vx + 1;
      else if (vx > 0)  vx = vx - 1;
      else if (vx < 0)  vx = vx + 1;
    end
    vy = s.vy;
    if (s.gr != 0 && k == KJ)       vy = -jv[i];
    else if (s.gr != 0)             vy = 0;
    else if (s.gc == gp[i] - 1)     vy = vy + 1;
    vx = sat(vx);
    vy = sat(vy);
    cx = s.px + vx;
    cy = s.py + vy;
    if (cx > XHI || cx < XLO) begin
      n.px = (cx > XHI) ? XHI : XLO;
      n.vx = (wm[i] != 0) ? -vx : 0;
    end else begin
      n.px = cx;
      n.vx = vx;
    end
    if (cy >= YHI)     begin n.py = YHI; n.vy = 0;  end
    else if (cy < YLO) begin n.py = YLO; n.vy = 0;  end
    else               begin n.py = cy;  n.vy = vy; end
    n.gr = (n.py == YHI) ? 1 : 0;
    n.ax = (s.ax + 1) % 4;
    n.gc = (s.gc + 1) % gp[i];
    return n;
  endfunction

  always @(posedge frame_clk) begin
    for (int i = 0; i < 2; i++) m[i] = step(m[i], i, Reset, bus0.Pause, bus0.keycode);
    if (!Reset) mvalid = 1'b1;
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, st_t s, int px, int py, int vx, int vy, int gr, int sz);
    chk({tag, "_posx"}, px, s.px);
    chk({tag, "_posy"}, py, s.py);
    chk({tag, "_velx"}, vx, s.vx);
    chk({tag, "_vely"}, vy, s.vy);
    chk({tag, "_grounded"}, gr, s.gr);
    chk({tag, "_size"}, sz, 4);
  endtask

  always @(negedge frame_clk) begin
    if (mvalid) begin
      chk_all("d0", m[0], int'(bus0.PosX), int'(bus0.PosY), sv(bus0.VelX), sv(bus0.VelY),
              int'(bus0.Grounded), int'(bus0.Size));
      chk_all("d1", m[1], int'(bus1.PosX), int'(bus1.PosY), sv(bus1.VelX), sv(bus1.VelY),
              int'(bus1.Grounded), int'(bus1.Size));
    end
  end

  task automatic lit(string nm, int dut, int mdl, int exp);
    chk({nm, "_dut"}, dut, exp);
    chk({nm, "_model"}, mdl, exp);
  endtask

  task automatic drive(logic rn, logic pz, logic [7:0] k);
    Reset        = rn;
    bus0.Pause   = pz;
    bus1.Pause   = pz;
    bus0.keycode = k;
    bus1.keycode = k;
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  initial begin
    int   min_d, min_m, found;
    st_t  snap;
    logic [7:0] key;

    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    lit("rst_px", int'(bus0.PosX), m[0].px, 320);
    lit("rst_py", int'(bus0.PosY), m[0].py, 240);
    lit("rst_vx", sv(bus0.VelX), m[0].vx, 0);
    lit("rst_vy", sv(bus0.VelY), m[0].vy, 0);
    lit("rst_gr", int'(bus0.Grounded), m[0].gr, 0);

    // Free fall
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    lit("fall_vy4", sv(bus0.VelY), m[0].vy, 1);
    lit("fall_py4", int'(bus0.PosY), m[0].py, 241);
    repeat (28) drive(1'b1, 1'b0, 8'h00);
    lit("fall_vy32", sv(bus0.VelY), m[0].vy, 8);
    for (int n = 0; n < 300 && !(bus0.Grounded && bus1.Grounded); n++) drive(1'b1, 1'b0, 8'h00);
    lit("land_py0", int'(bus0.PosY), m[0].py, 465);
    lit("land_vy0", sv(bus0.VelY), m[0].vy, 0);
    lit("land_gr0", int'(bus0.Grounded), m[0].gr, 1);
    lit("land_gr1", int'(bus1.Grounded), m[1].gr, 1);
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    lit("stay_py0", int'(bus0.PosY), m[0].py, 465);

    // Walk right then coast
    repeat (32) drive(1'b1, 1'b0, KR);
    lit("walk_vx0", sv(bus0.VelX), m[0].vx, 8);
    lit("walk_vx1", sv(bus1.VelX), m[1].vx, 8);
    repeat (32) drive(1'b1, 1'b0, 8'h00);
    lit("decay_vx0", sv(bus0.VelX), m[0].vx, 0);
    lit("decay_vx1", sv(bus1.VelX), m[1].vx, 0);

    // Jump, with a jump key pressed again while airborne; dut1 reaches the ceiling
    drive(1'b1, 1'b0, KJ);
    lit("jump_vy0", sv(bus0.VelY), m[0].vy, -6);
    lit("jump_py0", int'(bus0.PosY), m[0].py, 459);
    lit("jump_gr0", int'(bus0.Grounded), m[0].gr, 0);
    lit("jump_vy1", sv(bus1.VelY), m[1].vy, -8);
    lit("jump_py1", int'(bus1.PosY), m[1].py, 457);
    min_d = 1000;
    min_m = 1000;
    for (int n = 0; n < 400 && !(bus0.Grounded && bus1.Grounded); n++) begin
      drive(1'b1, 1'b0, (n >= 10 && n < 13) ? KJ : 8'h00);
      if (int'(bus1.PosY) < min_d) min_d = int'(bus1.PosY);
      if (m[1].py < min_m) min_m = m[1].py;
    end
    lit("ceil_py1", min_d, min_m, 14);
    lit("reland_py0", int'(bus0.PosY), m[0].py, 465);
    lit("reland_py1", int'(bus1.PosY), m[1].py, 465);
    lit("reland_gr1", int'(bus1.Grounded), m[1].gr, 1);

    // Left wall: clamp on dut0, bounce on dut1
    found = 0;
    for (int n = 0; n < 400 && found == 0; n++) begin
      drive(1'b1, 1'b0, KL);
      if (int'(bus0.PosX) == XLO && sv(bus0.VelX) == 0) found = 1;
    end
    chk("lwall_reached", found, 1);
    lit("lwall_px1", int'(bus1.PosX), m[1].px, 14);
    lit("lwall_vx1", sv(bus1.VelX), m[1].vx, 8);

    // Right wall on the clamp instance
    found = 0;
    for (int n = 0; n < 400 && found == 0; n++) begin
      drive(1'b1, 1'b0, KR);
      if (int'(bus0.PosX) == XHI) found = 1;
    end
    chk("rwall_reached", found, 1);
    lit("rwall_vx0", sv(bus0.VelX), m[0].vx, 0);

    // Pause mid-flight
    drive(1'b1, 1'b0, KJ);
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    snap = m[0];
    for (int n = 0; n < 10; n++) drive(1'b1, 1'b1, 8'($urandom));
    lit("pause_py0", int'(bus0.PosY), m[0].py, snap.py);
    lit("pause_vy0", sv(bus0.VelY), m[0].vy, snap.vy);
    repeat (6) drive(1'b1, 1'b0, 8'h00);

    // Reset mid-flight
    drive(1'b1, 1'b0, KJ);
    repeat (3) drive(1'b1, 1'b0, KR);
    drive(1'b0, 1'b0, KR);
    lit("mrst_px1", int'(bus1.PosX), m[1].px, 320);
    lit("mrst_py1", int'(bus1.PosY), m[1].py, 240);
    lit("mrst_vy1", sv(bus1.VelY), m[1].vy, 0);
    lit("mrst_vx0", sv(bus0.VelX), m[0].vx, 0);

    // Random key runs with occasional pause and reset
    key = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: key = KL;
          3, 4, 5: key = KR;
          6, 7:    key = KJ;
          8:       key = 8'h00;
          default: key = 8'($urandom);
        endcase
      end
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 24) == 0), key);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
